// File: rtl/ahfp_accum_pkg.sv
// Shared definitions for the ahfp_accum float accumulator: command codes,
// FSM state encodings, IEEE-754 single constants and a leading-zero counter.
package ahfp_accum_pkg;

  localparam logic [2:0] AHFP_CMD_CLEAR = 3'd0;
  localparam logic [2:0] AHFP_CMD_ADD   = 3'd1;
  localparam logic [2:0] AHFP_CMD_ADD2  = 3'd2;
  localparam logic [2:0] AHFP_CMD_READ  = 3'd3;
  localparam logic [2:0] AHFP_CMD_SUB   = 3'd4;

  localparam logic [1:0] AHFP_ST_IDLE = 2'd0;
  localparam logic [1:0] AHFP_ST_ADD1 = 2'd1;
  localparam logic [1:0] AHFP_ST_ADD2 = 2'd2;
  localparam logic [1:0] AHFP_ST_FIN  = 2'd3;

  localparam logic [31:0] AHFP_ZERO     = 32'h0000_0000;
  localparam logic [31:0] AHFP_QNAN     = 32'h7FC0_0000;
  localparam int          AHFP_SIGN_BIT = 31;
  localparam logic [7:0]  AHFP_EXP_MAX  = 8'hFF;

  // Number of leading zeros in a 27-bit magnitude; 27 when the value is zero.
  function automatic logic [4:0] lzc27(input logic [26:0] v);
    logic [4:0] cnt;
    logic       found;
    cnt   = 5'd27;
    found = 1'b0;
    for (int i = 26; i >= 0; i--) begin
      if (!found && v[i]) begin
        cnt   = 5'(26 - i);
        found = 1'b1;
      end
    end
    return cnt;
  endfunction

endpackage

// File: rtl/ahfp_add_sub.sv
// Combinational IEEE-754 single-precision adder, round-to-nearest-even with
// denormal support; subtraction is expressed by the caller through the sign bit.
module ahfp_add_sub
  import ahfp_accum_pkg::*;
(
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] sum_o
);

  logic        a_big;
  logic [31:0] x;
  logic [31:0] y;
  logic        eff_sub;
  logic [8:0]  ex;
  logic [8:0]  ey;
  logic [23:0] mx;
  logic [23:0] my;
  logic [8:0]  ediff;
  logic [26:0] y_ext;
  logic [26:0] y_shift;
  logic        y_sticky;
  logic [27:0] mag;
  logic [4:0]  lz;
  logic [4:0]  lshift;
  logic [26:0] norm;
  logic [8:0]  e_norm;
  logic        rnd_up;
  logic [24:0] rounded;
  logic [8:0]  e_fin;
  logic [22:0] mant;
  logic        x_nan;
  logic        x_inf;
  logic        y_inf;

  always_comb begin
    // NOTE: every variable gets a value on every path through this block, so
    // no latch can be inferred.
    lshift = '0;

    // x always carries the larger magnitude, so x - y never goes negative.
    a_big   = (a_i[30:0] >= b_i[30:0]);
    x       = a_big ? a_i : b_i;
    y       = a_big ? b_i : a_i;
    eff_sub = x[AHFP_SIGN_BIT] ^ y[AHFP_SIGN_BIT];

    ex = (x[30:23] == 8'd0) ? 9'd1 : {1'b0, x[30:23]};
    ey = (y[30:23] == 8'd0) ? 9'd1 : {1'b0, y[30:23]};
    mx = {(x[30:23] != 8'd0), x[22:0]};
    my = {(y[30:23] != 8'd0), y[22:0]};

    ediff = ex - ey;
    y_ext = {my, 3'b000};
    if (ediff >= 9'd27) begin
      y_shift  = '0;
      y_sticky = |my;
    end else begin
      y_shift  = y_ext >> ediff;
      y_sticky = |(y_ext & ~({27{1'b1}} << ediff));
    end
    y_shift[0] = y_shift[0] | y_sticky;

    if (eff_sub) mag = {1'b0, mx, 3'b000} - {1'b0, y_shift};
    else         mag = {1'b0, mx, 3'b000} + {1'b0, y_shift};

    lz = lzc27(mag[26:0]);
    if (mag[27]) begin
      norm   = {mag[27:2], mag[1] | mag[0]};
      e_norm = ex + 9'd1;
    end else begin
      // Left shift stops at exponent 1 so tiny results land as denormals.
      if ({4'b0, lz} > (ex - 9'd1)) lshift = 5'(ex - 9'd1);
      else                          lshift = lz;
      norm   = mag[26:0] << lshift;
      e_norm = ex - {4'b0, lshift};
    end

    rnd_up  = norm[2] & (norm[1] | norm[0] | norm[3]);
    rounded = {1'b0, norm[26:3]} + {24'd0, rnd_up};
    if (rounded[24]) begin
      e_fin = e_norm + 9'd1;
      mant  = rounded[23:1];
    end else begin
      e_fin = rounded[23] ? e_norm : 9'd0;
      mant  = rounded[22:0];
    end

    x_nan = (x[30:23] == AHFP_EXP_MAX) && (x[22:0] != 23'd0);
    x_inf = (x[30:23] == AHFP_EXP_MAX) && (x[22:0] == 23'd0);
    y_inf = (y[30:23] == AHFP_EXP_MAX) && (y[22:0] == 23'd0);

    if (x_nan)
      sum_o = {x[AHFP_SIGN_BIT], AHFP_EXP_MAX, 1'b1, x[21:0]};
    else if (x_inf && y_inf && eff_sub)
      sum_o = AHFP_QNAN;
    else if (x_inf)
      sum_o = x;
    else if (mag == 28'd0)
      sum_o = {x[AHFP_SIGN_BIT] & ~eff_sub, 31'd0};
    else if (e_fin >= {1'b0, AHFP_EXP_MAX})
      sum_o = {x[AHFP_SIGN_BIT], AHFP_EXP_MAX, 23'd0};
    else
      sum_o = {x[AHFP_SIGN_BIT], e_fin[7:0], mant};
  end

endmodule

// File: rtl/ahfp_accum.sv
// Multi-cycle float accumulator custom instruction around one ahfp_add_sub.
// Optional SUB command (n=4) is compiled in when AHFP_ACCUM_SUB_EN is defined.
module ahfp_accum
  import ahfp_accum_pkg::*;
#(
  parameter int WAIT_CYC = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [2:0]  n,
  input  logic [31:0] dataa,
  input  logic [31:0] datab,
  output logic        done,
  output logic [31:0] result
);

  localparam logic [3:0] CNT_RELOAD = 4'(WAIT_CYC - 1);

  logic [1:0]  state_q, state_d;
  logic        two_q, two_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] opa_q, opa_d;
  logic [31:0] opb_q, opb_d;
  logic [31:0] acc_q, acc_d;
  logic [31:0] result_q, result_d;
  logic [31:0] add_b;
  logic [31:0] add_sum;

  assign add_b = (state_q == AHFP_ST_ADD2) ? opb_q : opa_q;

  ahfp_add_sub u_add_sub (
    .a_i   (acc_q),
    .b_i   (add_b),
    .sum_o (add_sum)
  );

  always_comb begin
    state_d  = state_q;
    two_d    = two_q;
    cnt_d    = cnt_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    acc_d    = acc_q;
    result_d = result_q;

    case (state_q)
      AHFP_ST_IDLE: begin
        if (start) begin
          opa_d = dataa;
          opb_d = datab;
          cnt_d = CNT_RELOAD;
          two_d = 1'b0;
          case (n)
            AHFP_CMD_CLEAR: begin
              acc_d   = AHFP_ZERO;
              state_d = AHFP_ST_FIN;
            end
            AHFP_CMD_ADD:  state_d = AHFP_ST_ADD1;
            AHFP_CMD_ADD2: begin
              two_d   = 1'b1;
              state_d = AHFP_ST_ADD1;
            end
`ifdef AHFP_ACCUM_SUB_EN
            AHFP_CMD_SUB: begin
              opa_d[AHFP_SIGN_BIT] = ~dataa[AHFP_SIGN_BIT];
              state_d              = AHFP_ST_ADD1;
            end
`endif
            default: state_d = AHFP_ST_FIN;
          endcase
        end
      end
      AHFP_ST_ADD1: begin
        if (cnt_q == 4'd0) begin
          acc_d = add_sum;
          if (two_q) begin
            cnt_d   = CNT_RELOAD;
            state_d = AHFP_ST_ADD2;
          end else begin
            state_d = AHFP_ST_FIN;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      AHFP_ST_ADD2: begin
        if (cnt_q == 4'd0) begin
          acc_d   = add_sum;
          state_d = AHFP_ST_FIN;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = AHFP_ST_IDLE;
    endcase

    // Load result on the edge entering FIN so it is valid while done is high.
    if (state_d == AHFP_ST_FIN) result_d = acc_d;
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state is written with non-blocking assignments only, so
    // every register samples the pre-edge values of the others.
    if (!reset_n) begin
      state_q  <= AHFP_ST_IDLE;
      acc_q    <= AHFP_ZERO;
      result_q <= AHFP_ZERO;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      result_q <= result_d;
    end
  end

  // NOTE: operand, counter and command registers are deliberately not reset;
  // they are always reloaded on start before anything reads them.
  always_ff @(posedge clk) begin
    two_q <= two_d;
    cnt_q <= cnt_d;
    opa_q <= opa_d;
    opb_q <= opb_d;
  end

  assign done   = (state_q == AHFP_ST_FIN);
  assign result = result_q;

endmodule
